// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/arith/move/mult, a restoring divider
// with stall, HI/LO registers, EX/MEM pipeline register and forwarding bus.
module ex_stage #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alusel_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        ex_wreg_o,
    output logic [4:0]  ex_wd_o,
    output logic [31:0] ex_wdata_o,
    output logic        mem_wreg_o,
    output logic [4:0]  mem_wd_o,
    output logic [31:0] mem_wdata_o
);
    localparam logic [2:0] SEL_NOP    = 3'b000;
    localparam logic [2:0] SEL_LOGIC  = 3'b001;
    localparam logic [2:0] SEL_MOVE   = 3'b011;
    localparam logic [2:0] SEL_ARITH  = 3'b100;
    localparam logic [2:0] SEL_MULDIV = 3'b101;

    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_ANDI  = 8'b0101_1001;
    localparam logic [7:0] OP_ORI   = 8'b0101_1010;
    localparam logic [7:0] OP_XORI  = 8'b0101_1011;
    localparam logic [7:0] OP_LUI   = 8'b0101_1100;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    localparam int              CW   = $clog2(DIV_ITERS);
    localparam logic [CW-1:0]   LAST = CW'(DIV_ITERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [31:0] hi, lo;
    logic [31:0] res;
    logic [2:0]  cls;
    logic        wr_ok, known, is_div, sdiv, smul;
    logic [63:0] mul_a, mul_b, prod;

    // divider datapath: dq shifts dividend out and quotient in
    logic [31:0]   dq, rem, dvs;
    logic          neg_q, neg_r;
    logic [CW-1:0] cnt;
    logic [32:0]   rem_sh, diff;
    logic [31:0]   a_abs, b_abs, q_fin, r_fin;

    // op decode and single-cycle result; op only counts if alusel agrees
    always_comb begin
        res   = '0;
        cls   = SEL_NOP;
        wr_ok = 1'b0;
        case (aluop_i)
            OP_AND,  OP_ANDI: begin res = reg1_i & reg2_i;    cls = SEL_LOGIC; wr_ok = 1'b1; end
            OP_OR,   OP_ORI:  begin res = reg1_i | reg2_i;    cls = SEL_LOGIC; wr_ok = 1'b1; end
            OP_XOR,  OP_XORI: begin res = reg1_i ^ reg2_i;    cls = SEL_LOGIC; wr_ok = 1'b1; end
            OP_NOR:           begin res = ~(reg1_i | reg2_i); cls = SEL_LOGIC; wr_ok = 1'b1; end
            OP_LUI:           begin res = reg2_i;             cls = SEL_LOGIC; wr_ok = 1'b1; end
            OP_ADD:           begin res = reg1_i + reg2_i;    cls = SEL_ARITH; wr_ok = 1'b1; end
            OP_SUB:           begin res = reg1_i - reg2_i;    cls = SEL_ARITH; wr_ok = 1'b1; end
            OP_SLT:  begin res = {31'b0, $signed(reg1_i) < $signed(reg2_i)}; cls = SEL_ARITH; wr_ok = 1'b1; end
            OP_SLTU: begin res = {31'b0, reg1_i < reg2_i};                   cls = SEL_ARITH; wr_ok = 1'b1; end
            OP_MFHI:          begin res = hi; cls = SEL_MOVE; wr_ok = 1'b1; end
            OP_MFLO:          begin res = lo; cls = SEL_MOVE; wr_ok = 1'b1; end
            OP_MTHI, OP_MTLO: cls = SEL_MOVE;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: cls = SEL_MULDIV;
            default: ;
        endcase
    end

    assign known  = (cls != SEL_NOP) && (alusel_i == cls);
    assign is_div = known && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
    assign sdiv   = (aluop_i == OP_DIV);
    assign smul   = (aluop_i == OP_MULT);

    // one 64x64 multiplier: low 64 bits of sign/zero-extended operands
    assign mul_a = {{32{smul & reg1_i[31]}}, reg1_i};
    assign mul_b = {{32{smul & reg2_i[31]}}, reg2_i};
    assign prod  = mul_a * mul_b;

    assign a_abs  = (sdiv && reg1_i[31]) ? -reg1_i : reg1_i;
    assign b_abs  = (sdiv && reg2_i[31]) ? -reg2_i : reg2_i;
    assign rem_sh = {rem, dq[31]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign q_fin  = neg_q ? -dq  : dq;
    assign r_fin  = neg_r ? -rem : rem;

    assign ex_wreg_o  = rst & known & wr_ok & wreg_i;
    assign ex_wd_o    = rst ? wd_i : 5'd0;
    assign ex_wdata_o = (rst && known) ? res : 32'd0;

    // divider FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // divider FSM next state; flush always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (is_div) state_nxt = (reg2_i == 32'd0) ? DONE : BUSY;
            BUSY: if (cnt == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    // divider FSM output: hold the front end while a division is in flight
    always_comb begin
        stall_o = rst && !flush_i && ((state == IDLE && is_div) || state == BUSY);
    end

    // divider datapath: latch operands on entry, one restoring step per BUSY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq <= '0; rem <= '0; dvs <= '0; neg_q <= 1'b0; neg_r <= 1'b0; cnt <= '0;
        end else if (state == IDLE && is_div && !flush_i) begin
            cnt <= '0;
            if (reg2_i == 32'd0) begin
                dq <= 32'hFFFF_FFFF; rem <= reg1_i; neg_q <= 1'b0; neg_r <= 1'b0;
            end else begin
                dq    <= a_abs;
                rem   <= '0;
                dvs   <= b_abs;
                neg_q <= sdiv & (reg1_i[31] ^ reg2_i[31]);
                neg_r <= sdiv & reg1_i[31];
            end
        end else if (state == BUSY) begin
            rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
            dq  <= {dq[30:0], ~diff[32]};
            cnt <= cnt + 1'b1;
        end
    end

    // HI/LO writes: divider result on DONE, else MT*/MULT from the current op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush_i) begin
            if (state == DONE) begin
                hi <= r_fin;
                lo <= q_fin;
            end else if (state == IDLE && known) begin
                case (aluop_i)
                    OP_MTHI:           hi <= reg1_i;
                    OP_MTLO:           lo <= reg1_i;
                    OP_MULT, OP_MULTU: {hi, lo} <= prod;
                    default: ;
                endcase
            end
        end
    end

    // EX/MEM register; stall inserts a bubble, flush clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush_i || stall_o) begin
            mem_wreg_o  <= 1'b0;
            mem_wd_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_wreg_o  <= ex_wreg_o;
            mem_wd_o    <= ex_wd_o;
            mem_wdata_o <= ex_wdata_o;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases from the datasheet plus random ops
// checked against an arithmetic model of HI/LO and results.
module tb_ex_stage;
    localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_MOVE = 3'b011, SEL_ARITH = 3'b100, SEL_MULDIV = 3'b101;
    localparam logic [7:0] AND_ = 8'h24, OR_ = 8'h25, XOR_ = 8'h26, NOR_ = 8'h27;
    localparam logic [7:0] ANDI = 8'h59, ORI = 8'h5A, XORI = 8'h5B, LUI = 8'h5C;
    localparam logic [7:0] SLT = 8'h2A, SLTU = 8'h2B, ADD = 8'h20, SUB = 8'h22;
    localparam logic [7:0] MFHI = 8'h10, MTHI = 8'h11, MFLO = 8'h12, MTLO = 8'h13;
    localparam logic [7:0] MULT = 8'h18, MULTU = 8'h19, DIV = 8'h1A, DIVU = 8'h1B;

    logic        clk = 1'b0, rst = 1'b0;
    logic [2:0]  alusel_i;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, flush_i;
    logic        stall_o, ex_wreg_o, mem_wreg_o;
    logic [4:0]  ex_wd_o, mem_wd_o;
    logic [31:0] ex_wdata_o, mem_wdata_o;

    int checks = 0, failures = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .alusel_i(alusel_i), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .stall_o(stall_o), .ex_wreg_o(ex_wreg_o),
        .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o), .mem_wreg_o(mem_wreg_o),
        .mem_wd_o(mem_wd_o), .mem_wdata_o(mem_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // reference: {writes_reg, result} from the instruction semantics
    function automatic logic [32:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            AND_, ANDI: return {1'b1, a & b};
            OR_,  ORI:  return {1'b1, a | b};
            XOR_, XORI: return {1'b1, a ^ b};
            NOR_:       return {1'b1, ~(a | b)};
            LUI:        return {1'b1, b};
            ADD:        return {1'b1, a + b};
            SUB:        return {1'b1, a - b};
            SLT:        return {1'b1, (int'(a) < int'(b)) ? 32'd1 : 32'd0};
            SLTU:       return {1'b1, (longint'({32'b0, a}) < longint'({32'b0, b})) ? 32'd1 : 32'd0};
            MFHI:       return {1'b1, m_hi};
            MFLO:       return {1'b1, m_lo};
            default:    return {1'b0, 32'd0};
        endcase
    endfunction

    function automatic logic [2:0] cls_of(input logic [7:0] op);
        case (op)
            ADD, SUB, SLT, SLTU:          return SEL_ARITH;
            MFHI, MFLO, MTHI, MTLO:       return SEL_MOVE;
            MULT, MULTU, DIV, DIVU:       return SEL_MULDIV;
            default:                      return SEL_LOGIC;
        endcase
    endfunction

    // called at posedge+1; returns at posedge+1 of the following cycle
    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr);
        logic [32:0] e;
        longint sp;
        logic [63:0] up;
        alusel_i = cls_of(op); aluop_i = op; reg1_i = a; reg2_i = b;
        wd_i = wd; wreg_i = wr; flush_i = 1'b0;
        e = model(op, a, b);
        @(negedge clk);
        check("stall_single", {31'b0, stall_o}, 32'd0);
        check("ex_wreg", {31'b0, ex_wreg_o}, {31'b0, e[32] & wr});
        check("ex_wd", {27'b0, ex_wd_o}, {27'b0, wd});
        if (e[32] || op == 8'hFF) check("ex_wdata", ex_wdata_o, e[31:0]);
        @(posedge clk); #1;
        case (op)
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            MULT: begin sp = longint'(int'(a)) * longint'(int'(b)); m_hi = sp[63:32]; m_lo = sp[31:0]; end
            MULTU: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
            default: ;
        endcase
        check("mem_wreg", {31'b0, mem_wreg_o}, {31'b0, e[32] & wr});
        check("mem_wd", {27'b0, mem_wd_o}, {27'b0, wd});
        if (e[32]) check("mem_wdata", mem_wdata_o, e[31:0]);
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int n;
        longint qa, rb;
        logic [31:0] eq, er;
        alusel_i = SEL_MULDIV; aluop_i = sgn ? DIV : DIVU; reg1_i = a; reg2_i = b;
        wd_i = 5'd0; wreg_i = 1'b0; flush_i = 1'b0;
        if (b == 0) begin
            eq = 32'hFFFF_FFFF; er = a;
        end else if (sgn) begin
            qa = longint'(int'(a)) / longint'(int'(b));
            rb = longint'(int'(a)) % longint'(int'(b));
            eq = qa[31:0]; er = rb[31:0];
        end else begin
            eq = a / b; er = a % b;
        end
        n = 0;
        @(negedge clk);
        while (stall_o === 1'b1 && n < 60) begin n++; @(negedge clk); end
        check("div_stall_cycles", n, (b == 0) ? 32'd1 : 32'd33);
        check("div_done_wreg", {31'b0, ex_wreg_o}, 32'd0);
        check("div_bubble", {31'b0, mem_wreg_o}, 32'd0);
        @(posedge clk); #1;
        m_hi = er; m_lo = eq;
        do_op(MFLO, 0, 0, 5'd2, 1'b1);
        do_op(MFHI, 0, 0, 5'd3, 1'b1);
    endtask

    logic [7:0] rops [18] = '{AND_, OR_, XOR_, NOR_, ANDI, ORI, XORI, LUI, ADD, SUB,
                              SLT, SLTU, MFHI, MFLO, MTHI, MTLO, MULT, MULTU};

    initial begin
        alusel_i = SEL_LOGIC; aluop_i = ORI; reg1_i = 32'h1234; reg2_i = 32'h1;
        wd_i = 5'd7; wreg_i = 1'b1; flush_i = 1'b0;
        #12;
        check("rst_stall", {31'b0, stall_o}, 32'd0);
        check("rst_ex_wreg", {31'b0, ex_wreg_o}, 32'd0);
        check("rst_ex_wd", {27'b0, ex_wd_o}, 32'd0);
        check("rst_ex_wdata", ex_wdata_o, 32'd0);
        check("rst_mem_wreg", {31'b0, mem_wreg_o}, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        do_op(ORI, 32'h0000F0F0, 32'h00000F0F, 5'd1, 1'b1);
        do_op(SLT, 32'hFFFFFFFF, 32'd1, 5'd2, 1'b1);
        do_op(SLTU, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
        do_op(ADD, 32'h7FFFFFFF, 32'd1, 5'd4, 1'b1);
        do_op(NOR_, 32'hF0F0_0000, 32'h0000_00FF, 5'd0, 1'b1);
        do_op(8'hFF, 32'hDEAD_BEEF, 32'h1, 5'd5, 1'b1);
        do_op(MULT, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
        do_op(MFHI, 0, 0, 5'd6, 1'b1);
        do_op(MFLO, 0, 0, 5'd7, 1'b1);
        check("mult_hi_const", m_hi, 32'hFFFFFFFF);
        check("mult_lo_const", m_lo, 32'hFFFFFFFA);

        do_div(1'b1, 32'hFFFFFFF9, 32'd2);
        check("div_lo_const", m_lo, 32'hFFFFFFFD);
        do_div(1'b0, 32'd5, 32'd0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
        do_div(1'b1, 32'd100, 32'hFFFFFFF9);

        // flush in the middle of a division
        alusel_i = SEL_MULDIV; aluop_i = DIVU; reg1_i = 32'd1000; reg2_i = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_mem_wreg", {31'b0, mem_wreg_o}, 32'd0);
        check("flush_mem_wdata", mem_wdata_o, 32'd0);
        do_op(MFLO, 0, 0, 5'd8, 1'b1);
        do_op(MFHI, 0, 0, 5'd9, 1'b1);

        // flush beats a DIV presented in the same cycle
        alusel_i = SEL_MULDIV; aluop_i = DIV; reg1_i = 32'd9; reg2_i = 32'd2; flush_i = 1'b1;
        @(negedge clk);
        check("flush_div_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1;
        do_op(MFLO, 0, 0, 5'd10, 1'b1);

        // async reset mid-division
        do_op(MTHI, 32'h1234_5678, 0, 5'd0, 1'b0);
        do_op(MTLO, 32'h9ABC_DEF0, 0, 5'd0, 1'b0);
        alusel_i = SEL_MULDIV; aluop_i = DIVU; reg1_i = 32'd77; reg2_i = 32'd3; wd_i = 5'd5;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b0; #1;
        check("arst_stall", {31'b0, stall_o}, 32'd0);
        check("arst_ex_wd", {27'b0, ex_wd_o}, 32'd0);
        check("arst_ex_wdata", ex_wdata_o, 32'd0);
        check("arst_mem_wreg", {31'b0, mem_wreg_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; m_hi = 0; m_lo = 0;
        do_op(MFHI, 0, 0, 5'd11, 1'b1);
        do_op(MFLO, 0, 0, 5'd12, 1'b1);

        // random traffic, with occasional divides
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) do_div($urandom_range(0, 1) == 1, a, b);
            else do_op(rops[$urandom_range(0, 17)], a, b, 5'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
